// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arb_pkg
//  Purpose : Shared types and constants for the RAM port arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Registered owner of the RAM port.
  typedef enum logic [1:0] {
    FREE     = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_DMA = 2'd2
  } owner_e;

  // Bit positions inside the grant vector.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // Default geometry: 1K words of 12 bits.
  localparam int AMSB_DEF = 9;
  localparam int DMSB_DEF = 11;

endpackage
`default_nettype wire

// File: rtl/mem_port_arb_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_port_arb_if
//  Purpose : Requester and RAM-port bundle for the memory port arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface mem_port_arb_if
  import mem_arb_pkg::*;
#(
  parameter int AMSB = AMSB_DEF,
  parameter int DMSB = DMSB_DEF
);
  // CPU requester
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_lock;
  logic [AMSB:0] cpu_addr;
  logic [DMSB:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DMSB:0] cpu_rdata;
  // DMA / front-panel requester
  logic          dma_req;
  logic          dma_we;
  logic          dma_lock;
  logic [AMSB:0] dma_addr;
  logic [DMSB:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DMSB:0] dma_rdata;
  // RAM port
  logic          mem_wr;
  logic [AMSB:0] mem_ad;
  logic [DMSB:0] mem_din;
  logic [DMSB:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_wr, mem_ad, mem_din,
    input  mem_dout
  );

  // Requesters plus RAM side.
  modport master (
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_wr, mem_ad, mem_din,
    output mem_dout
  );
endinterface
`default_nettype wire

// File: rtl/arb_age_ctr.sv
`default_nettype none
// ============================================================================
//  Module  : arb_age_ctr
//  Purpose : Saturating count of consecutive denied DMA request cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module arb_age_ctr #(
  parameter int MAXWAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAXWAIT));

  // Clear has priority over increment; count holds once saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module  : mem_port_arb
//  Purpose : Shares one RAM port between CPU and DMA with lock and anti-
//            starvation aging; routes 1-cycle read data back to the reader.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AMSB    = AMSB_DEF,
  parameter int DMSB    = DMSB_DEF,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_port_arb_if.slave bus
);
  owner_e     state_q;
  owner_e     state_d;
  owner_e     owner;
  logic [1:0] gnt;
  logic       age_sat;
  logic       age_inc;
  logic       age_clr;
  logic       cpu_rv_q;
  logic       dma_rv_q;

  // A DMA request that is denied ages; any grant or idle DMA clears the age.
  assign age_inc = bus.dma_req && !gnt[REQ_DMA];
  assign age_clr = gnt[REQ_DMA] || !bus.dma_req;

  arb_age_ctr #(
    .MAXWAIT(MAXWAIT)
  ) u_age (
    .clk  (clk),
    .reset(reset),
    .inc  (age_inc),
    .clr  (age_clr),
    .sat  (age_sat)
  );

  // Resolve this cycle's owner, grant at most one requester, plan next owner.
  // A lock whose owner has dropped req is released in that same cycle.
  always_comb begin
    owner   = state_q;
    gnt     = 2'b00;
    state_d = FREE;
    if (state_q == LOCK_CPU && !bus.cpu_req) owner = FREE;
    if (state_q == LOCK_DMA && !bus.dma_req) owner = FREE;
    case (owner)
      LOCK_CPU: gnt[REQ_CPU] = 1'b1;
      LOCK_DMA: gnt[REQ_DMA] = 1'b1;
      default: begin
        if (bus.cpu_req && !(bus.dma_req && age_sat)) gnt[REQ_CPU] = 1'b1;
        else if (bus.dma_req)                         gnt[REQ_DMA] = 1'b1;
      end
    endcase
    if (reset) gnt = 2'b00;
    state_d = owner;
    if (gnt[REQ_CPU])      state_d = bus.cpu_lock ? LOCK_CPU : FREE;
    else if (gnt[REQ_DMA]) state_d = bus.dma_lock ? LOCK_DMA : FREE;
  end

  // Drive the RAM port from the granted requester, all zero when idle.
  always_comb begin
    bus.mem_wr  = 1'b0;
    bus.mem_ad  = {(AMSB+1){1'b0}};
    bus.mem_din = {(DMSB+1){1'b0}};
    if (gnt[REQ_CPU]) begin
      bus.mem_wr  = bus.cpu_we;
      bus.mem_ad  = bus.cpu_addr;
      bus.mem_din = bus.cpu_wdata;
    end else if (gnt[REQ_DMA]) begin
      bus.mem_wr  = bus.dma_we;
      bus.mem_ad  = bus.dma_addr;
      bus.mem_din = bus.dma_wdata;
    end
  end

  // Grant and read-return outputs; rvalid is masked while reset is held so a
  // read granted just before reset never reports data.
  always_comb begin
    bus.cpu_gnt    = gnt[REQ_CPU];
    bus.dma_gnt    = gnt[REQ_DMA];
    bus.cpu_rvalid = cpu_rv_q && !reset;
    bus.dma_rvalid = dma_rv_q && !reset;
    bus.cpu_rdata  = bus.mem_dout;
    bus.dma_rdata  = bus.mem_dout;
  end

  // Owner register and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FREE;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_rv_q <= gnt[REQ_CPU] && !bus.cpu_we;
      dma_rv_q <= gnt[REQ_DMA] && !bus.dma_we;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_mem_port_arb
//  Purpose : Self-checking bench for mem_port_arb with a registered RAM model
//            and per-requester read-data scoreboards.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  localparam int AMSB    = 9;
  localparam int DMSB    = 11;
  localparam int MAXWAIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arb_if #(.AMSB(AMSB), .DMSB(DMSB)) bus ();

  mem_port_arb #(
    .AMSB   (AMSB),
    .DMSB   (DMSB),
    .MAXWAIT(MAXWAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Registered-read RAM with a side preload port.
  logic [DMSB:0] ram   [0:1023];
  logic [DMSB:0] model [0:1023];
  logic          pl_en;
  logic [AMSB:0] pl_addr;
  logic [DMSB:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)           ram[pl_addr]    <= pl_data;
    else if (bus.mem_wr) ram[bus.mem_ad] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_ad];
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [DMSB:0] cpu_q[$];
  logic [DMSB:0] dma_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b0;
    bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = '0;  bus.dma_wdata = '0;
  endtask

  task automatic preload(input logic [AMSB:0] a, input logic [DMSB:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; model[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h055;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    step(); step();
    n_cmp++; if (bus.cpu_gnt !== 1'b0) begin n_err++; $display("FAIL reset_cpu_gnt: got %b want 0", bus.cpu_gnt); end
    n_cmp++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dma_gnt: got %b want 0", bus.dma_gnt); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_rvalid: got %b%b want 00", bus.cpu_rvalid, bus.dma_rvalid); end
    step();
    reset = 1'b0;
    idle();
    #1;
    n_cmp++; if (bus.mem_ad !== 10'h000 || bus.mem_din !== 12'h000 || bus.mem_wr !== 1'b0) begin
      n_err++; $display("FAIL idle_drive: got ad=%h din=%h wr=%b want 000/000/0", bus.mem_ad, bus.mem_din, bus.mem_wr); end
    step();
  endtask

  task automatic test_cpu_alone();
    logic [DMSB:0] e;
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'h012;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      n_err++; $display("FAIL alone_gnt: got cpu=%b dma=%b want 1/0", bus.cpu_gnt, bus.dma_gnt); end
    n_cmp++; if (bus.mem_ad !== 10'h012 || bus.mem_wr !== 1'b0) begin
      n_err++; $display("FAIL alone_mem: got ad=%h wr=%b want 012/0", bus.mem_ad, bus.mem_wr); end
    cpu_q.push_back(model[10'h012]);
    step();
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL alone_rvalid: got %b want 1", bus.cpu_rvalid); end
    else begin
      e = cpu_q.pop_front();
      n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL alone_rdata: got %h want %h", bus.cpu_rdata, e); end
    end
    n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_err++; $display("FAIL alone_dma_rvalid: got %b want 0", bus.dma_rvalid); end
    step();
  endtask

  task automatic test_contention();
    logic want_dma, cpu_pend, dma_pend;
    logic [DMSB:0] e;
    idle();
    step();
    for (int k = 0; k < 10; k++) begin
      bus.cpu_req = 1'b1; bus.cpu_addr = 10'h010;
      bus.dma_req = 1'b1; bus.dma_addr = 10'h020;
      #1;
      want_dma = ((k % (MAXWAIT + 1)) == MAXWAIT);
      n_cmp++; if (bus.cpu_gnt !== !want_dma || bus.dma_gnt !== want_dma) begin
        n_err++; $display("FAIL contend_gnt[%0d]: got cpu=%b dma=%b want %b/%b", k, bus.cpu_gnt, bus.dma_gnt, !want_dma, want_dma); end
      if (want_dma) dma_q.push_back(model[10'h020]);
      else          cpu_q.push_back(model[10'h010]);
      cpu_pend = !want_dma;
      dma_pend = want_dma;
      step();
      n_cmp++; if (bus.cpu_rvalid !== cpu_pend || bus.dma_rvalid !== dma_pend) begin
        n_err++; $display("FAIL contend_rvalid[%0d]: got cpu=%b dma=%b want %b/%b", k, bus.cpu_rvalid, bus.dma_rvalid, cpu_pend, dma_pend); end
      if (bus.cpu_rvalid === 1'b1 && cpu_q.size() > 0) begin
        e = cpu_q.pop_front();
        n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL contend_cpu_rdata[%0d]: got %h want %h", k, bus.cpu_rdata, e); end
      end
      if (bus.dma_rvalid === 1'b1 && dma_q.size() > 0) begin
        e = dma_q.pop_front();
        n_cmp++; if (bus.dma_rdata !== e) begin n_err++; $display("FAIL contend_dma_rdata[%0d]: got %h want %h", k, bus.dma_rdata, e); end
      end
    end
    idle();
    step();
  endtask

  task automatic test_lock();
    logic [DMSB:0] e;
    idle();
    step();
    // Build DMA age up to MAXWAIT-1 with plain CPU reads.
    for (int k = 0; k < MAXWAIT - 1; k++) begin
      bus.cpu_req = 1'b1; bus.cpu_addr = 10'h010;
      bus.dma_req = 1'b1; bus.dma_addr = 10'h200;
      #1;
      n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL lock_pre_gnt[%0d]: got %b want 1", k, bus.cpu_gnt); end
      step();
    end
    // Locked read; age saturates during it.
    bus.cpu_addr = 10'h100; bus.cpu_lock = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      n_err++; $display("FAIL lock_rd_gnt: got cpu=%b dma=%b want 1/0", bus.cpu_gnt, bus.dma_gnt); end
    cpu_q.push_back(model[10'h100]);
    step();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL lock_rvalid: got %b want 1", bus.cpu_rvalid); end
    else begin
      e = cpu_q.pop_front();
      n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL lock_rdata: got %h want %h", bus.cpu_rdata, e); end
    end
    // Unlocking write while DMA is saturated.
    bus.cpu_we = 1'b1; bus.cpu_wdata = 12'h001; bus.cpu_lock = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0 || bus.mem_wr !== 1'b1) begin
      n_err++; $display("FAIL lock_wr_gnt: got cpu=%b dma=%b wr=%b want 1/0/1", bus.cpu_gnt, bus.dma_gnt, bus.mem_wr); end
    model[10'h100] = 12'h001;
    step();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL lock_wr_rvalid: got %b want 0", bus.cpu_rvalid); end
    // DMA must win the first free cycle even with CPU still asking.
    bus.cpu_we = 1'b0; bus.cpu_addr = 10'h010;
    bus.dma_addr = 10'h100;
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
      n_err++; $display("FAIL lock_after_gnt: got cpu=%b dma=%b want 0/1", bus.cpu_gnt, bus.dma_gnt); end
    dma_q.push_back(model[10'h100]);
    step();
    idle();
    n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_err++; $display("FAIL lock_dma_rvalid: got %b want 1", bus.dma_rvalid); end
    else begin
      e = dma_q.pop_front();
      n_cmp++; if (bus.dma_rdata !== e) begin n_err++; $display("FAIL lock_dma_rdata: got %h want %h", bus.dma_rdata, e); end
    end
    step();
  endtask

  task automatic test_dma_lock();
    logic [DMSB:0] e;
    idle();
    step();
    for (int k = 0; k < 3; k++) begin
      bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 10'h006;
      if (k > 0) begin bus.cpu_req = 1'b1; bus.cpu_addr = 10'h005; end
      #1;
      n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
        n_err++; $display("FAIL dlock_gnt[%0d]: got cpu=%b dma=%b want 0/1", k, bus.cpu_gnt, bus.dma_gnt); end
      dma_q.push_back(model[10'h006]);
      step();
      n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_err++; $display("FAIL dlock_rvalid[%0d]: got %b want 1", k, bus.dma_rvalid); end
      else begin
        e = dma_q.pop_front();
        n_cmp++; if (bus.dma_rdata !== e) begin n_err++; $display("FAIL dlock_rdata[%0d]: got %h want %h", k, bus.dma_rdata, e); end
      end
    end
    bus.dma_req = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      n_err++; $display("FAIL dlock_release_gnt: got cpu=%b dma=%b want 1/0", bus.cpu_gnt, bus.dma_gnt); end
    cpu_q.push_back(model[10'h005]);
    step();
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL dlock_cpu_rvalid: got cpu=%b dma=%b want 1/0", bus.cpu_rvalid, bus.dma_rvalid); end
    else begin
      e = cpu_q.pop_front();
      n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL dlock_cpu_rdata: got %h want %h", bus.cpu_rdata, e); end
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [DMSB:0] e;
    idle();
    step();
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'h012;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rst_rd_gnt: got %b want 1", bus.cpu_gnt); end
    step();
    reset = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_wdata = 12'hFFF; bus.dma_req = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid_drop: got %b want 0", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_gnt !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drive: got cpu=%b dma=%b wr=%b want 0/0/0", bus.cpu_gnt, bus.dma_gnt, bus.mem_wr); end
    step();
    reset = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 10'h012;
    bus.dma_addr = 10'h020;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      n_err++; $display("FAIL rst_after_gnt: got cpu=%b dma=%b want 1/0", bus.cpu_gnt, bus.dma_gnt); end
    cpu_q.push_back(model[10'h012]);
    step();
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_after_rvalid: got cpu=%b dma=%b want 1/0", bus.cpu_rvalid, bus.dma_rvalid); end
    else begin
      e = cpu_q.pop_front();
      n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL rst_after_rdata: got %h want %h", bus.cpu_rdata, e); end
    end
    step();
  endtask

  task automatic test_write_through();
    logic [DMSB:0] e;
    idle();
    step();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'h3FF; bus.dma_wdata = 12'hABC;
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.mem_wr !== 1'b1) begin
      n_err++; $display("FAIL wt_gnt: got gnt=%b wr=%b want 1/1", bus.dma_gnt, bus.mem_wr); end
    n_cmp++; if (bus.mem_ad !== 10'h3FF || bus.mem_din !== 12'hABC) begin
      n_err++; $display("FAIL wt_mem: got ad=%h din=%h want 3ff/abc", bus.mem_ad, bus.mem_din); end
    model[10'h3FF] = 12'hABC;
    step();
    idle();
    n_cmp++; if (bus.dma_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      n_err++; $display("FAIL wt_no_rvalid: got cpu=%b dma=%b want 0/0", bus.cpu_rvalid, bus.dma_rvalid); end
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'h3FF;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL wt_rd_gnt: got %b want 1", bus.cpu_gnt); end
    cpu_q.push_back(model[10'h3FF]);
    step();
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL wt_rd_rvalid: got %b want 1", bus.cpu_rvalid); end
    else begin
      e = cpu_q.pop_front();
      n_cmp++; if (bus.cpu_rdata !== e) begin n_err++; $display("FAIL wt_rd_rdata: got %h want %h", bus.cpu_rdata, e); end
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    for (int i = 0; i < 1024; i++) model[i] = '0;
    preload(10'h012, 12'h7A5);
    preload(10'h010, 12'h5C3);
    preload(10'h020, 12'h2E7);
    preload(10'h100, 12'h3C3);
    preload(10'h200, 12'h0F0);
    preload(10'h005, 12'h155);
    preload(10'h006, 12'h6A9);
    preload(10'h3FF, 12'h111);

    test_reset();
    test_cpu_alone();
    test_contention();
    test_lock();
    test_dma_lock();
    test_reset_mid_read();
    test_write_through();

    n_cmp++; if (cpu_q.size() != 0 || dma_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got cpu=%0d dma=%0d left want 0/0", cpu_q.size(), dma_q.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Shares one port of the dual-port 12-bit program/data RAM between the CPU core and the DMA/front-panel loader.
- Grants one requester per cycle and drives the RAM port: address, write data and write enable.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Supports atomic read-modify-write (ISZ, auto-index) through a lock, and prevents DMA starvation with an age counter.

Parameters:
AMSB, 9, MSB of word address (1K words)
DMSB, 11, MSB of data word
MAXWAIT, 4, consecutive denied DMA request cycles before DMA is forced to win the next arbitration

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, level, held until granted
cpu_we  in  1  CPU write (1) / read (0)
cpu_lock  in  1  CPU keeps ownership for the following cycle
cpu_addr  in  AMSB+1  CPU word address
cpu_wdata  in  DMSB+1  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  cpu_rdata valid (one cycle after granted read)
cpu_rdata  out  DMSB+1  read data to CPU
dma_req, dma_we, dma_lock, dma_addr, dma_wdata  in  1/1/1/AMSB+1/DMSB+1  same as CPU counterparts
dma_gnt, dma_rvalid, dma_rdata  out  1/1/DMSB+1  same as CPU counterparts
mem_wr  out  1  RAM write enable
mem_ad  out  AMSB+1  RAM address
mem_din  out  DMSB+1  RAM write data
mem_dout  in  DMSB+1  RAM registered read data

Behaviour:
- Timing: gnt is combinational from req and registered state. A granted request drives mem_* in the same cycle, and the RAM samples on the next posedge. rvalid is asserted the cycle after a granted read (we=0).
- rdata paths: cpu_rdata and dma_rdata both equal mem_dout; only rvalid qualifies them. A granted write produces no rvalid.
- Idle drive: with no grant, mem_wr=0, mem_ad=0, mem_din=0.
- FSM states, registered owner:
  - FREE to LOCK_CPU: CPU granted with cpu_lock=1.
  - FREE to LOCK_DMA: DMA granted with dma_lock=1.
  - LOCK_x to FREE: owner granted with lock=0, or owner drops req.
  - In LOCK_x, only x may be granted; the other requester waits regardless of age.
- Arbitration in FREE:
  - CPU wins by default.
  - DMA wins if age==MAXWAIT or cpu_req=0.
  - A single requester is always granted immediately.
- Age counter (width clog2(MAXWAIT+1)):
  - Increments each cycle dma_req=1 && dma_gnt=0, saturating at MAXWAIT.
  - Clears on dma_gnt, or when dma_req=0.
  - Still counts during LOCK_CPU, so DMA wins the first FREE cycle once the lock ends.
- Lock release: lock asserted without req is ignored and does not change state. A lock is released the cycle its owner's req falls.
- Reset: while reset=1 both gnt=0 and mem_wr=0. Registered state goes to FREE, age=0, cpu_rvalid=dma_rvalid=0. This holds even if a read was granted the cycle before: its rvalid is dropped.
- Invariants: never both gnt; rvalid never on both; at most one access per cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner enum (FREE, LOCK_CPU, LOCK_DMA);
  - requester index constants (REQ_CPU=0, REQ_DMA=1);
  - default AMSB/DMSB.
- One sub-module, arb_age_ctr: saturating age counter with inputs inc, clr, reset and output sat.
- Remainder flat: about 150-200 lines.

Test Plan:
- CPU alone: cpu_req read addr 0x012, RAM holds 0x7A5 → cpu_gnt same cycle, cpu_rvalid next cycle, cpu_rdata=0x7A5, dma_rvalid=0.
- Contention: both read every cycle with MAXWAIT=4 → CPU granted 4 cycles, DMA granted on 5th cycle, age returns to 0, then pattern repeats.
- Lock: CPU reads 0x100 with lock=1 while dma_req=1, next cycle CPU writes 0x100=0x001 with lock=0 → DMA not granted in either cycle. DMA is granted the cycle after and reads 0x001.
- DMA lock: DMA granted with lock=1 for 3 cycles while cpu_req held → CPU denied throughout, granted the first cycle DMA drops lock or req.
- Reset mid-read: CPU read granted, reset=1 next cycle → cpu_rvalid=0, gnt=0, mem_wr=0. After reset release with both requesting, CPU wins because age=0.
- Write-through: DMA write 0x3FF=0xABC → mem_wr=1, mem_ad=0x3FF, mem_din=0xABC, no rvalid. A following CPU read of 0x3FF returns 0xABC.
